hazard_control_unit: RTL and testbench
======================================

HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 The block SHALL have input clk (1): clock; all state updates on rising edge.
REQ-002 The block SHALL have input rst (1): reset, asynchronous, active-high.
REQ-003 The block SHALL have inputs id_valid (1), id_rs1 [4:0] and id_rs2 [4:0]: valid flag and scalar sources of the instruction in ID.
REQ-004 The block SHALL have inputs id_vec_op (1), id_vs1 [4:0], id_vs2 [4:0] and id_vec_cycles [2:0]: vector-op flag, vector sources and EX occupancy of the ID instruction (0 is treated as 1).
REQ-005 The block SHALL have inputs ex_reg_write (1), ex_rd [4:0] and ex_mem_to_reg [1:0]: ID/EX stage scalar writeback info (2'b01 = load).
REQ-006 The block SHALL have inputs ex_vd [4:0] and ex_branch_taken (1): ID/EX vector destination and taken-branch resolution in EX.
REQ-007 The block SHALL have outputs stall_if (1) and stall_id (1): hold PC and the IF/ID register.
REQ-008 The block SHALL have outputs flush_ifid (1) and flush_idex (1): clear IF/ID, or load a bubble into ID/EX with all write enables 0.
REQ-009 The block SHALL have outputs state [1:0] (debug FSM state) and stall_cycles [15:0] (performance counter).

Function
REQ-010 The FSM SHALL have states RUN=0, FLUSH=1 and VEC_BUSY=2; encoding 3 SHALL be unreachable and SHALL recover to RUN.
REQ-011 Hazard detection SHALL be combinational (Mealy) on the current state and inputs, with priority branch > load-use > vector.
REQ-012 On ex_branch_taken=1, flush_ifid and flush_idex SHALL be 1 in that cycle, the other outputs 0, and the FSM SHALL enter FLUSH.
REQ-013 In FLUSH, load-use and vector detection SHALL be suppressed for exactly one cycle, then the FSM SHALL return to RUN, or to VEC_BUSY if the vector counter is nonzero.
REQ-014 A load-use hazard is ex_mem_to_reg==2'b01 && ex_reg_write && ex_rd!=0 && id_valid && (ex_rd==id_rs1 || ex_rd==id_rs2); on it stall_if=stall_id=flush_idex=1 for that cycle only.
REQ-015 A vector op issues when id_valid && id_vec_op and no stall or flush is asserted; the vector counter SHALL then load max(id_vec_cycles,1)-1, busy_vd SHALL capture ex_vd on the following edge, and the FSM SHALL go to VEC_BUSY if the loaded value is nonzero.
REQ-016 In VEC_BUSY, the counter SHALL decrement by 1 per cycle and the FSM SHALL return to RUN when it reaches 0.
REQ-017 In VEC_BUSY, an ID vector op, or a vector source equal to busy_vd, SHALL assert stall_if=stall_id=flush_idex=1; scalar ops SHALL proceed.
REQ-018 A taken branch during VEC_BUSY SHALL flush (REQ-012) without clearing the vector counter.
REQ-019 stall_cycles SHALL increment on every cycle with stall_id=1 and SHALL saturate at 16'hFFFF.
REQ-020 Register 0 SHALL never cause a scalar hazard.

Reset
REQ-021 While rst=1, all outputs SHALL be 0: stall_if, stall_id, flush_ifid, flush_idex, state=RUN, stall_cycles=0.
REQ-022 Reset SHALL also clear the vector counter and busy_vd to 0.
REQ-023 Reset asserted mid-stall or mid-VEC_BUSY SHALL abort the operation immediately, with no residual stall after release.

Configuration
REQ-024 With macro VECTOR_HAZARD_EN defined, the vector counter, busy_vd and VEC_BUSY state SHALL be present as specified.
REQ-025 Without VECTOR_HAZARD_EN, the vector inputs SHALL be ignored, VEC_BUSY SHALL be unreachable, and no vector stall SHALL occur.

Structure
REQ-026 Package hazard_pkg SHALL hold the state enum typedef, the constant MEM_TO_REG_LOAD=2'b01, and the widths of the vector counter (3) and the perf counter (16).
REQ-027 The vector occupancy counter and busy_vd SHALL be a sub-module vec_busy_counter, instantiated only under VECTOR_HAZARD_EN.

Verification
REQ-028 Load-use: ex_mem_to_reg=01, ex_reg_write=1, ex_rd=5, id_rs2=5 -> one cycle of stall_if=stall_id=flush_idex=1, stall_cycles=1.
REQ-029 x0 load: same as REQ-028 but ex_rd=0, id_rs1=0 -> no stall.
REQ-030 Branch plus load-use in the same cycle -> flush_ifid=flush_idex=1, stall_id=0, state=FLUSH for 1 cycle, then RUN.
REQ-031 Vector op issue with id_vec_cycles=4, then a vector op in ID -> stalled 3 cycles, issues on the 4th; a scalar op in between is not stalled.
REQ-032 Reset asserted in VEC_BUSY with counter=2 -> all outputs 0 at once; after release, a vector op issues without a stall.
REQ-033 Drive 70000 stall cycles -> stall_cycles holds 16'hFFFF.

Source files
------------

// File: rtl/hazard_pkg.sv
// ============================================================================
// Module     : hazard_pkg
// Description: Shared types and constants for the hazard control unit:
//              FSM state encoding, the load writeback selector value and the
//              widths of the vector occupancy and stall performance counters.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

package hazard_pkg;

  // Encoding 2'd3 is intentionally unused; the FSM recovers from it to RUN.
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_VEC_BUSY = 2'd2
  } hz_state_t;

  localparam logic [1:0] MEM_TO_REG_LOAD = 2'b01;

  localparam int VCNT_W = 3;
  localparam int PERF_W = 16;

endpackage : hazard_pkg

`default_nettype wire

// File: rtl/vec_busy_counter.sv
// ============================================================================
// Module     : vec_busy_counter
// Description: Tracks how many more cycles a multi-cycle vector op occupies EX
//              and which vector register it will write.
//   clk, rst        : clock, asynchronous active-high reset
//   i_load          : vector op issues this cycle
//   i_load_val      : remaining occupancy to load (already max(n,1)-1)
//   i_dec           : decrement request (one per VEC_BUSY cycle)
//   i_ex_vd         : vector destination currently in ID/EX
//   o_count         : remaining busy cycles
//   o_busy_vd       : destination register of the busy vector op
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module vec_busy_counter
  import hazard_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [VCNT_W-1:0] i_load_val,
  input  logic              i_dec,
  input  logic [4:0]        i_ex_vd,
  output logic [VCNT_W-1:0] o_count,
  output logic [4:0]        o_busy_vd
);

  logic [VCNT_W-1:0] r_count;
  logic [4:0]        r_busy_vd;
  logic              r_cap_pending;

  // The issuing op only reaches ID/EX one edge after issue, so its
  // destination is captured on the edge after the counter loads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count       <= '0;
      r_busy_vd     <= '0;
      r_cap_pending <= 1'b0;
    end else begin
      if (i_load) begin
        r_count <= i_load_val;
      end else if (i_dec && (r_count != '0)) begin
        r_count <= r_count - 1'b1;
      end
      r_cap_pending <= i_load;
      if (r_cap_pending) begin
        r_busy_vd <= i_ex_vd;
      end
    end
  end

  assign o_count   = r_count;
  assign o_busy_vd = r_busy_vd;

endmodule : vec_busy_counter

`default_nettype wire

// File: rtl/hazard_control_unit.sv
// ============================================================================
// Module     : hazard_control_unit
// Description: Pipeline hazard controller. Mealy detection of taken-branch
//              flushes, load-use stalls and (optionally) vector occupancy
//              stalls, with priority branch > load-use > vector.
//   Inputs : clk, rst, id_valid, id_rs1, id_rs2, id_vec_op, id_vs1, id_vs2,
//            id_vec_cycles, ex_reg_write, ex_rd, ex_mem_to_reg, ex_vd,
//            ex_branch_taken
//   Outputs: stall_if, stall_id, flush_ifid, flush_idex, state[1:0],
//            stall_cycles[15:0]
// Configuration: define VECTOR_HAZARD_EN to enable vector occupancy tracking
//              (VEC_BUSY state, vec_busy_counter). Undefined: vector inputs
//              are ignored.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_control_unit
  import hazard_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_vec_op,
  input  logic [4:0]  id_vs1,
  input  logic [4:0]  id_vs2,
  input  logic [2:0]  id_vec_cycles,
  input  logic        ex_reg_write,
  input  logic [4:0]  ex_rd,
  input  logic [1:0]  ex_mem_to_reg,
  input  logic [4:0]  ex_vd,
  input  logic        ex_branch_taken,
  output logic        stall_if,
  output logic        stall_id,
  output logic        flush_ifid,
  output logic        flush_idex,
  output logic [1:0]  state,
  output logic [15:0] stall_cycles
);

  hz_state_t         r_state;
  hz_state_t         w_state_nxt;
  logic [PERF_W-1:0] r_stall_cycles;

  logic              w_load_use;
  logic              w_vec_req;
  logic              w_vec_hazard;
  logic              w_vec_issue;
  logic [VCNT_W-1:0] w_vec_load_val;
  logic [VCNT_W-1:0] w_vcnt;
  logic              w_stall;
  logic              w_flush_ifid;
  logic              w_flush_idex;

  // x0 is hardwired, so a load targeting it never creates a dependency.
  assign w_load_use = (ex_mem_to_reg == MEM_TO_REG_LOAD) && ex_reg_write &&
                      (ex_rd != 5'd0) && id_valid &&
                      ((ex_rd == id_rs1) || (ex_rd == id_rs2));

`ifdef VECTOR_HAZARD_EN
  logic [4:0] w_busy_vd;

  assign w_vec_req      = id_valid && id_vec_op;
  assign w_vec_hazard   = id_valid &&
                          (id_vec_op || (id_vs1 == w_busy_vd) || (id_vs2 == w_busy_vd));
  // Occupancy 0 behaves like 1, i.e. no extra busy cycles.
  assign w_vec_load_val = (id_vec_cycles == 3'd0) ? 3'd0 : (id_vec_cycles - 3'd1);

  vec_busy_counter u_vec_busy_counter (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_vec_issue),
    .i_load_val (w_vec_load_val),
    .i_dec      (r_state == ST_VEC_BUSY),
    .i_ex_vd    (ex_vd),
    .o_count    (w_vcnt),
    .o_busy_vd  (w_busy_vd)
  );
`else
  logic w_unused_vec;

  assign w_vec_req      = 1'b0;
  assign w_vec_hazard   = 1'b0;
  assign w_vec_load_val = '0;
  assign w_vcnt         = '0;
  assign w_unused_vec   = ^{id_vec_op, id_vs1, id_vs2, id_vec_cycles, ex_vd, w_vec_issue};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_stall      = 1'b0;
    w_flush_ifid = 1'b0;
    w_flush_idex = 1'b0;
    w_vec_issue  = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (ex_branch_taken) begin
          w_flush_ifid = 1'b1;
          w_flush_idex = 1'b1;
          w_state_nxt  = ST_FLUSH;
        end else if (w_load_use) begin
          w_stall = 1'b1;
        end else if (w_vec_req) begin
          w_vec_issue = 1'b1;
          if (w_vec_load_val != '0) begin
            w_state_nxt = ST_VEC_BUSY;
          end
        end
      end
      // Shadow cycle after a flush: the ID contents are dead, so only a new
      // branch is honoured. The vector counter is frozen here.
      ST_FLUSH: begin
        if (ex_branch_taken) begin
          w_flush_ifid = 1'b1;
          w_flush_idex = 1'b1;
          w_state_nxt  = ST_FLUSH;
        end else begin
          w_state_nxt = (w_vcnt != '0) ? ST_VEC_BUSY : ST_RUN;
        end
      end
      // Counter decrements every cycle in this state, including a branch
      // cycle; a branch flushes but leaves the occupancy in place.
      ST_VEC_BUSY: begin
        if (ex_branch_taken) begin
          w_flush_ifid = 1'b1;
          w_flush_idex = 1'b1;
          w_state_nxt  = ST_FLUSH;
        end else begin
          if (w_load_use || w_vec_hazard) begin
            w_stall = 1'b1;
          end
          w_state_nxt = (w_vcnt <= 3'd1) ? ST_RUN : ST_VEC_BUSY;
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cycles <= '0;
    end else if (w_stall && (r_stall_cycles != '1)) begin
      r_stall_cycles <= r_stall_cycles + 1'b1;
    end
  end

  // Detection is combinational, so outputs are forced low while reset is
  // held rather than waiting for the registered state to clear.
  assign stall_if     = w_stall & ~rst;
  assign stall_id     = w_stall & ~rst;
  assign flush_ifid   = w_flush_ifid & ~rst;
  assign flush_idex   = (w_flush_idex | w_stall) & ~rst;
  assign state        = r_state;
  assign stall_cycles = r_stall_cycles;

endmodule : hazard_control_unit

`default_nettype wire

// File: tb/tb_hazard_control_unit.sv
// ============================================================================
// Module     : tb_hazard_control_unit
// Description: Self-checking bench for hazard_control_unit. A driver applies
//              directed and random cycles, a behavioural model pushes the
//              expected per-cycle outputs into a queue, and a monitor pops and
//              compares them against the DUT on the falling edge.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_control_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2;
  logic        id_vec_op;
  logic [4:0]  id_vs1, id_vs2;
  logic [2:0]  id_vec_cycles;
  logic        ex_reg_write;
  logic [4:0]  ex_rd;
  logic [1:0]  ex_mem_to_reg;
  logic [4:0]  ex_vd;
  logic        ex_branch_taken;
  logic        stall_if, stall_id, flush_ifid, flush_idex;
  logic [1:0]  state;
  logic [15:0] stall_cycles;

  always #5 clk = ~clk;

  hazard_control_unit dut (
    .clk             (clk),
    .rst             (rst),
    .id_valid        (id_valid),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_vec_op       (id_vec_op),
    .id_vs1          (id_vs1),
    .id_vs2          (id_vs2),
    .id_vec_cycles   (id_vec_cycles),
    .ex_reg_write    (ex_reg_write),
    .ex_rd           (ex_rd),
    .ex_mem_to_reg   (ex_mem_to_reg),
    .ex_vd           (ex_vd),
    .ex_branch_taken (ex_branch_taken),
    .stall_if        (stall_if),
    .stall_id        (stall_id),
    .flush_ifid      (flush_ifid),
    .flush_idex      (flush_idex),
    .state           (state),
    .stall_cycles    (stall_cycles)
  );

  typedef struct packed {
    logic        sif;
    logic        sid;
    logic        fif;
    logic        fid;
    logic [1:0]  st;
    logic [15:0] sc;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: pipeline "mode" expressed as a flush flag plus the
  // number of remaining busy cycles of the outstanding vector op.
  bit         m_flush;
  int         m_busy;
  logic [4:0] m_vd;
  bit         m_cap;
  int         m_stalls;

  task automatic model_reset();
    m_flush  = 0;
    m_busy   = 0;
    m_vd     = 5'd0;
    m_cap    = 0;
    m_stalls = 0;
  endtask

  // Compute this cycle's expected outputs from the current inputs, queue
  // them, then advance the model across the coming clock edge.
  task automatic model_step();
    exp_t e;
    bit   br, lu, vh, iss;
    e = '0;
    if (rst) begin
      q.push_back(e);
      model_reset();
      return;
    end
    e.st = m_flush ? 2'd1 : ((m_busy > 0) ? 2'd2 : 2'd0);
    e.sc = m_stalls[15:0];
    br  = ex_branch_taken;
    lu  = !m_flush && (ex_mem_to_reg == 2'b01) && ex_reg_write && (ex_rd != 0) &&
          id_valid && ((ex_rd == id_rs1) || (ex_rd == id_rs2));
    vh  = 0;
    iss = 0;
`ifdef VECTOR_HAZARD_EN
    vh  = !m_flush && (m_busy > 0) && id_valid &&
          (id_vec_op || (id_vs1 == m_vd) || (id_vs2 == m_vd));
    iss = !m_flush && (m_busy == 0) && id_valid && id_vec_op && !br && !lu;
`endif
    if (br) begin
      e.fif = 1'b1;
      e.fid = 1'b1;
    end else if (lu || vh) begin
      e.sif = 1'b1;
      e.sid = 1'b1;
      e.fid = 1'b1;
    end
    q.push_back(e);
    if (e.sid && m_stalls < 65535) m_stalls++;
    if (m_cap) m_vd = ex_vd;
    m_cap = iss;
    if (!m_flush && m_busy > 0) m_busy--;
    if (iss) m_busy = (id_vec_cycles == 0) ? 0 : int'(id_vec_cycles) - 1;
    m_flush = br;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0;
    id_vec_op = 0; id_vs1 = 0; id_vs2 = 0; id_vec_cycles = 0;
    ex_reg_write = 0; ex_rd = 0; ex_mem_to_reg = 0; ex_vd = 0;
    ex_branch_taken = 0;
  endtask

  task automatic set_rand();
    id_valid        = ($urandom_range(0, 9) < 8);
    id_rs1          = 5'($urandom_range(0, 3));
    id_rs2          = 5'($urandom_range(0, 3));
    id_vec_op       = ($urandom_range(0, 9) < 3);
    id_vs1          = 5'($urandom_range(0, 7));
    id_vs2          = 5'($urandom_range(0, 7));
    id_vec_cycles   = 3'($urandom_range(0, 7));
    ex_reg_write    = ($urandom_range(0, 9) < 7);
    ex_rd           = 5'($urandom_range(0, 3));
    ex_mem_to_reg   = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'($urandom_range(0, 3));
    ex_vd           = 5'($urandom_range(0, 7));
    ex_branch_taken = ($urandom_range(0, 99) < 8);
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every cycle the DUT presents a full output vector.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      tests++;
      if ({stall_if, stall_id, flush_ifid, flush_idex, state, stall_cycles} !== e) begin
        fails++;
        if (fails <= 40)
          $display("FAIL cycle_outputs t=%0t got sif=%b sid=%b fif=%b fid=%b st=%0d sc=%0d expected sif=%b sid=%b fif=%b fid=%b st=%0d sc=%0d",
                   $time, stall_if, stall_id, flush_ifid, flush_idex, state, stall_cycles,
                   e.sif, e.sid, e.fif, e.fid, e.st, e.sc);
      end
    end
  end

  initial begin
    rst = 1'b1;
    set_idle();
    model_reset();
    @(posedge clk);
    #1;

    // Reset state, with a load-use pattern present to show outputs gated.
    ex_mem_to_reg = 2'b01; ex_reg_write = 1; ex_rd = 5'd5; id_valid = 1; id_rs2 = 5'd5;
    tick();
    tick();
    rst = 1'b0;
    set_idle();
    tick();

    // Load-use on rs2: one stall cycle, counter becomes 1.
    ex_mem_to_reg = 2'b01; ex_reg_write = 1; ex_rd = 5'd5; id_valid = 1; id_rs1 = 5'd3; id_rs2 = 5'd5;
    tick();
    set_idle();
    chk16("load_use_stall_count", stall_cycles, 16'd1);
    tick();

    // Load to x0 must not stall.
    ex_mem_to_reg = 2'b01; ex_reg_write = 1; ex_rd = 5'd0; id_valid = 1; id_rs1 = 5'd0; id_rs2 = 5'd0;
    tick();
    set_idle();

    // Branch together with load-use: branch wins, one FLUSH cycle.
    ex_branch_taken = 1; ex_mem_to_reg = 2'b01; ex_reg_write = 1; ex_rd = 5'd6; id_valid = 1; id_rs1 = 5'd6;
    tick();
    set_idle();
    chk16("branch_enters_flush", {14'd0, state}, 16'd1);
    tick();
    chk16("flush_returns_run", {14'd0, state}, 16'd0);
    tick();

    // Vector op of 4 cycles, then vector ops and a scalar op in between.
    id_valid = 1; id_vec_op = 1; id_vec_cycles = 3'd4; id_vs1 = 5'd1; id_vs2 = 5'd2;
    tick();
    ex_vd = 5'd7;
    tick();
    id_vec_op = 0; id_vs1 = 5'd3; id_vs2 = 5'd4; ex_vd = 5'd0;
    tick();
    id_vec_op = 1; id_vs1 = 5'd1; id_vs2 = 5'd2;
    tick();
    id_vec_cycles = 3'd1;
    tick();
    set_idle();
    tick();

    // Reset in the middle of a vector busy period.
    id_valid = 1; id_vec_op = 1; id_vec_cycles = 3'd4;
    tick();
    set_idle();
    tick();
    rst = 1'b1;
    id_valid = 1; id_vec_op = 1; id_vec_cycles = 3'd4; ex_branch_taken = 1;
    tick();
    rst = 1'b0;
    set_idle();
    id_valid = 1; id_vec_op = 1; id_vec_cycles = 3'd1;
    tick();
    set_idle();
    tick();

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      set_rand();
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0;
    set_idle();
    tick();

    // Counter saturation: continuous load-use stalls.
    ex_mem_to_reg = 2'b01; ex_reg_write = 1; ex_rd = 5'd5; id_valid = 1; id_rs1 = 5'd0; id_rs2 = 5'd5;
    for (int i = 0; i < 70000; i++) tick();
    set_idle();
    chk16("stall_cycles_saturated", stall_cycles, 16'hFFFF);
    tick();

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_hazard_control_unit

`default_nettype wire
